ascon_result_collector: RTL and testbench
=========================================

// Module: ascon_result_collector
// PURPOSE
//  Downstream stage of the SoC encryption wrapper. Requests the result readout, captures the
//  8-bit cipher/tag byte stream and reassembles it into a Y-bit ciphertext and a 128-bit tag.
//  Optionally compares the tag against an expected value. Presents parallel results plus done/error
//  flags to the host register file.
// PARAMETERS
//  Y          16   ciphertext length in bits; multiple of 8, 8..128
//  FIRST_LAT  2    cycles from the reg_outxSO pulse cycle to the first valid ciphertext byte
//  GAP        1    invalid byte cycles between the last ciphertext byte and the first tag byte
// PORTS
//  clk              in   1     single clock; all logic on posedge
//  rst              in   1     synchronous, active-low reset
//  collect_startxSI in   1     host pulse: begin one readout
//  enc_readyxSI     in   1     encryption done/ready from the encryption wrapper
//  cipher_tagxSI    in   8     serial byte stream from the encryption wrapper
//  exp_tagxSI       in   128   expected tag for the compare
//  reg_outxSO       out  1     one-cycle readout request to the encryption wrapper
//  cipher_textxSO   out  Y     assembled ciphertext, first byte in the MSBs
//  tagxSO           out  128   assembled tag, first byte in the MSBs
//  busyxSO          out  1     high from accepted start until DONE/ERR
//  donexSO          out  1     sticky; results valid
//  tag_matchxSO     out  1     tagxSO == exp_tagxSI; meaningful only while donexSO=1
//  errorxSO         out  1     sticky; enc_readyxSI dropped during readout
// BEHAVIOUR
//  Reset (rst=0 at posedge): state IDLE, all outputs and counters 0. This also applies mid-readout:
//   partial data is discarded.
//  States:
//   IDLE - On collect_startxSI, clear done/error/match, set busy, and go to ARM.
//   ARM  - Wait for enc_readyxSI=1. The ARM->REQ transition drives reg_outxSO=1 for exactly that
//          one cycle, then goes to WAIT.
//   WAIT - Wait FIRST_LAT-1 cycles, then go to CT.
//   CT   - For Y/8 consecutive cycles, shift cipher_tagxSI into a ciphertext shift register
//          (sr <= {sr[Y-9:0], byte}), then go to GAP.
//   GAP  - Ignore the stream for GAP cycles; GAP=0 skips this state. Then go to TAG.
//   TAG  - For 16 consecutive cycles, shift the byte into the tag shift register, then go to DONE.
//   DONE - Set donexSO=1. Copy shift registers into cipher_textxSO/tagxSO. Register tag_matchxSO.
//          Clear busy and return to IDLE.
//  - Output registers update only in DONE; they hold their value during the next readout until
//    that readout completes.
//  - Byte counter: 5 bits; resets on each state entry; no wrap within a phase.
//  - Latency: the first ciphertext byte is sampled FIRST_LAT cycles after the reg_outxSO cycle.
//    donexSO rises Y/8+GAP+16+1 cycles after that first sample.
//  - enc_readyxSI=0 in any of WAIT/CT/GAP/TAG: go to IDLE, set errorxSO=1, clear busy, leave
//    output registers unchanged.
//  - collect_startxSI while busy is ignored.
//  - collect_startxSI in the same cycle as DONE is ignored; the host re-issues it.
//  - collect_startxSI together with rst=0: reset wins.
//  - reg_outxSO is never asserted outside the ARM->REQ transition.
// TESTING
//  1. Y=16. Pulse start with enc_ready=1. Stream A5,C3, one gap byte 00, then tag bytes 00..0F.
//     Expect: reg_outxSO high for 1 cycle; cipher_textxSO=16'hA5C3;
//     tagxSO=128'h000102030405060708090A0B0C0D0E0F; donexSO=1; busyxSO=0.
//  2. Same stream with exp_tagxSI equal to the streamed tag -> tag_matchxSO=1.
//     Flip bit 0 of exp_tagxSI -> tag_matchxSO=0.
//  3. Pulse start with enc_ready=0 for 10 cycles, then raise it.
//     Expect: no reg_outxSO during the wait; exactly one pulse after enc_ready rises;
//     correct capture afterwards.
//  4. Drop enc_ready during the 5th tag byte.
//     Expect: errorxSO=1; busyxSO=0; outputs keep the previous results; no donexSO.
//  5. Assert rst=0 during the CT phase.
//     Expect: next cycle all outputs 0 and state IDLE; a new start completes normally.
//  6. Y=128, GAP=0: stream 32 sequential bytes 10..2F.
//     Expect: cipher_textxSO=128'h101112...1F; tagxSO=128'h202122...2F.
//     Also: a second start pulse while busy is ignored.

Source files
------------

// File: rtl/ascon_result_collector.sv
// Result collector for the encryption wrapper: requests the readout, deserialises the
// ciphertext/tag byte stream, compares the tag and presents sticky done/error flags.
module ascon_result_collector #(
  parameter int Y         = 16,
  parameter int FIRST_LAT = 2,
  parameter int GAP       = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           collect_startxSI,
  input  logic           enc_readyxSI,
  input  logic [7:0]     cipher_tagxSI,
  input  logic [127:0]   exp_tagxSI,
  output logic           reg_outxSO,
  output logic [Y-1:0]   cipher_textxSO,
  output logic [127:0]   tagxSO,
  output logic           busyxSO,
  output logic           donexSO,
  output logic           tag_matchxSO,
  output logic           errorxSO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_REQ,
    S_WAIT,
    S_CT,
    S_GAP,
    S_TAG,
    S_DONE
  } state_t;

  // Last counter value of each timed phase; the counter restarts at 0 on every state entry.
  localparam logic [4:0] WAIT_LAST = 5'((FIRST_LAT > 1) ? FIRST_LAT - 2 : 0);
  localparam logic [4:0] CT_LAST   = 5'(Y / 8 - 1);
  localparam logic [4:0] GAP_LAST  = 5'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [4:0] TAG_LAST  = 5'd15;

  state_t         state;
  state_t         state_next;
  logic [4:0]     cnt;

  logic           in_stream;
  logic           accept;
  logic           abort;
  logic           finish;
  logic           shift_ct;
  logic           shift_tag;

  logic [Y-1:0]   ct_sr;
  logic [127:0]   tag_sr;
  logic [Y+7:0]   ct_shift;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  assign in_stream = (state == S_WAIT) || (state == S_CT) ||
                     (state == S_GAP)  || (state == S_TAG);

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_next
    // unassigned and no latch is inferred.
    state_next = state;
    unique case (state)
      S_IDLE: if (collect_startxSI) state_next = S_ARM;
      S_ARM:  if (enc_readyxSI)     state_next = S_REQ;
      S_REQ:  state_next = (FIRST_LAT > 1) ? S_WAIT : S_CT;
      S_WAIT: if (cnt == WAIT_LAST) state_next = S_CT;
      S_CT: begin
        if (cnt == CT_LAST) state_next = (GAP > 0) ? S_GAP : S_TAG;
      end
      S_GAP:  if (cnt == GAP_LAST)  state_next = S_TAG;
      S_TAG:  if (cnt == TAG_LAST)  state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Losing the ready handshake mid-readout overrides any phase progress.
    if (in_stream && !enc_readyxSI) state_next = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_outxSO = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    shift_ct   = 1'b0;
    shift_tag  = 1'b0;
    abort      = in_stream && !enc_readyxSI;
    unique case (state)
      S_IDLE:  accept     = collect_startxSI;
      S_REQ:   reg_outxSO = 1'b1;
      S_CT:    shift_ct   = 1'b1;
      S_TAG:   shift_tag  = 1'b1;
      S_DONE:  finish     = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Phase counter: cleared on every state change, saturating inside a phase
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if (cnt != 5'h1f) begin
      cnt <= cnt + 5'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift registers and host-visible result registers
  // ---------------------------------------------------------------------------
  // Widened concatenation keeps the shift legal for Y = 8 as well.
  assign ct_shift = {ct_sr, cipher_tagxSI};

  always_ff @(posedge clk) begin
    if (!rst) begin
      ct_sr          <= '0;
      tag_sr         <= '0;
      cipher_textxSO <= '0;
      tagxSO         <= '0;
      busyxSO        <= 1'b0;
      donexSO        <= 1'b0;
      tag_matchxSO   <= 1'b0;
      errorxSO       <= 1'b0;
    end else begin
      if (accept) begin
        busyxSO      <= 1'b1;
        donexSO      <= 1'b0;
        errorxSO     <= 1'b0;
        tag_matchxSO <= 1'b0;
      end
      if (shift_ct) begin
        ct_sr <= ct_shift[Y-1:0];
      end
      if (shift_tag) begin
        tag_sr <= {tag_sr[119:0], cipher_tagxSI};
      end
      // Results become visible only once a readout has fully completed.
      if (finish) begin
        busyxSO        <= 1'b0;
        donexSO        <= 1'b1;
        cipher_textxSO <= ct_sr;
        tagxSO         <= tag_sr;
        tag_matchxSO   <= (tag_sr == exp_tagxSI);
      end
      if (abort) begin
        busyxSO  <= 1'b0;
        errorxSO <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ascon_result_collector.sv
// Directed bench for ascon_result_collector: a Y=16/GAP=1 instance and a Y=128/GAP=0
// instance share clock, reset and stream inputs but have separate start strobes.
module tb_ascon_result_collector;

  localparam int FIRST_LAT = 2;

  localparam logic [15:0]  CT_A   = 16'hA5C3;
  localparam logic [127:0] TAG_A  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] CT_B   = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] TAG_B  = 128'h202122232425262728292A2B2C2D2E2F;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_a;
  logic           start_b;
  logic           enc_ready;
  logic [7:0]     cipher_tag;
  logic [127:0]   exp_tag;

  logic           reg_out_a, busy_a, done_a, match_a, error_a;
  logic [15:0]    ct_a;
  logic [127:0]   tag_a;
  logic           reg_out_b, busy_b, done_b, match_b, error_b;
  logic [127:0]   ct_b;
  logic [127:0]   tag_b;

  logic [7:0]     stream [0:47];
  int             checks = 0;
  int             errors = 0;
  int             pulses_a = 0;
  int             pulses_b = 0;
  int             snap;

  always #5 clk = ~clk;

  ascon_result_collector #(.Y(16), .FIRST_LAT(FIRST_LAT), .GAP(1)) dut_a (
    .clk              (clk),
    .rst              (rst),
    .collect_startxSI (start_a),
    .enc_readyxSI     (enc_ready),
    .cipher_tagxSI    (cipher_tag),
    .exp_tagxSI       (exp_tag),
    .reg_outxSO       (reg_out_a),
    .cipher_textxSO   (ct_a),
    .tagxSO           (tag_a),
    .busyxSO          (busy_a),
    .donexSO          (done_a),
    .tag_matchxSO     (match_a),
    .errorxSO         (error_a)
  );

  ascon_result_collector #(.Y(128), .FIRST_LAT(FIRST_LAT), .GAP(0)) dut_b (
    .clk              (clk),
    .rst              (rst),
    .collect_startxSI (start_b),
    .enc_readyxSI     (enc_ready),
    .cipher_tagxSI    (cipher_tag),
    .exp_tagxSI       (exp_tag),
    .reg_outxSO       (reg_out_b),
    .cipher_textxSO   (ct_b),
    .tagxSO           (tag_b),
    .busyxSO          (busy_b),
    .donexSO          (done_b),
    .tag_matchxSO     (match_b),
    .errorxSO         (error_b)
  );

  // Request pulses are counted on the rising edge; the bench only reads them at falling edges.
  always @(posedge clk) begin
    if (reg_out_a) pulses_a <= pulses_a + 1;
    if (reg_out_b) pulses_b <= pulses_b + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic val);
    if (sel) start_b = val;
    else     start_a = val;
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
  endtask

  task automatic fill_a();
    stream[0] = 8'hA5;
    stream[1] = 8'hC3;
    stream[2] = 8'h00;
    for (int i = 0; i < 16; i++) stream[3+i] = 8'(i);
  endtask

  task automatic fill_b();
    for (int i = 0; i < 32; i++) stream[i] = 8'(8'h10 + i);
  endtask

  // Waits for the request, streams nbytes starting FIRST_LAT cycles later, then checks
  // that done rises exactly one cycle after the DONE state. abort_at/rst_at stop early.
  task automatic feed(input bit sel, input int nbytes, input int abort_at,
                      input int rst_at, input int restart_at);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = sel ? reg_out_b : reg_out_a;
    end
    check("req_seen", 128'(seen), 128'd1);
    if (!seen) return;
    repeat (FIRST_LAT) @(negedge clk);
    for (int i = 0; i < nbytes; i++) begin
      cipher_tag = stream[i];
      set_start(sel, i == restart_at);
      if (i == abort_at) enc_ready = 1'b0;
      if (i == rst_at)   rst = 1'b0;
      @(negedge clk);
      set_start(sel, 1'b0);
      if (i == abort_at || i == rst_at) begin
        cipher_tag = 8'h00;
        return;
      end
    end
    cipher_tag = 8'h00;
    set_start(sel, restart_at == nbytes);
    @(negedge clk);
    set_start(sel, 1'b0);
    check("done_latency", 128'(sel ? done_b : done_a), 128'd1);
    check("busy_at_done", 128'(sel ? busy_b : busy_a), 128'd0);
  endtask

  initial begin
    rst        = 1'b0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    enc_ready  = 1'b0;
    cipher_tag = 8'h00;
    exp_tag    = '0;
    repeat (3) @(negedge clk);
    check("rst_done_a", 128'(done_a), 128'd0);
    check("rst_busy_a", 128'(busy_a), 128'd0);
    check("rst_ct_a",   128'(ct_a),   128'd0);
    check("rst_reg_b",  128'(reg_out_b), 128'd0);
    check("rst_tag_b",  tag_b, 128'd0);
    rst = 1'b1;

    // 1: basic capture, matching tag
    fill_a();
    enc_ready = 1'b1;
    exp_tag   = TAG_A;
    snap      = pulses_a;
    pulse_start(1'b0);
    check("t1_busy", 128'(busy_a), 128'd1);
    feed(1'b0, 19, -1, -1, -1);
    check("t1_pulses", 128'(pulses_a - snap), 128'd1);
    check("t1_ct",     128'(ct_a), 128'(CT_A));
    check("t1_tag",    tag_a, TAG_A);
    check("t1_match",  128'(match_a), 128'd1);
    check("t1_error",  128'(error_a), 128'd0);

    // 2: mismatching tag, plus a start in the DONE cycle that must be dropped
    exp_tag = TAG_A ^ 128'd1;
    snap    = pulses_a;
    pulse_start(1'b0);
    feed(1'b0, 19, -1, -1, 19);
    check("t2_match", 128'(match_a), 128'd0);
    repeat (4) @(negedge clk);
    check("t2_done_start_ignored", 128'(busy_a), 128'd0);
    check("t2_pulses", 128'(pulses_a - snap), 128'd1);

    // 3: start while the wrapper is not ready
    exp_tag   = TAG_A;
    enc_ready = 1'b0;
    snap      = pulses_a;
    pulse_start(1'b0);
    repeat (10) @(negedge clk);
    check("t3_no_req_wait", 128'(pulses_a - snap), 128'd0);
    enc_ready = 1'b1;
    feed(1'b0, 19, -1, -1, -1);
    check("t3_pulses", 128'(pulses_a - snap), 128'd1);
    check("t3_ct",     128'(ct_a), 128'(CT_A));
    check("t3_tag",    tag_a, TAG_A);
    check("t3_match",  128'(match_a), 128'd1);

    // 4: ready drops on the 5th tag byte (stream index 2 ct + 1 gap + 4)
    pulse_start(1'b0);
    feed(1'b0, 19, 7, -1, -1);
    check("t4_error", 128'(error_a), 128'd1);
    check("t4_busy",  128'(busy_a),  128'd0);
    check("t4_done",  128'(done_a),  128'd0);
    check("t4_ct_kept",  128'(ct_a), 128'(CT_A));
    check("t4_tag_kept", tag_a, TAG_A);
    enc_ready = 1'b1;
    repeat (25) @(negedge clk);
    check("t4_no_late_done", 128'(done_a), 128'd0);

    // 5: reset during the ciphertext phase, then a clean readout
    pulse_start(1'b0);
    feed(1'b0, 19, -1, 1, -1);
    check("t5_rst_error", 128'(error_a), 128'd0);
    check("t5_rst_busy",  128'(busy_a),  128'd0);
    check("t5_rst_ct",    128'(ct_a),    128'd0);
    check("t5_rst_tag",   tag_a,         128'd0);
    check("t5_rst_req",   128'(reg_out_a), 128'd0);
    rst = 1'b1;
    pulse_start(1'b0);
    feed(1'b0, 19, -1, -1, -1);
    check("t5_ct",    128'(ct_a), 128'(CT_A));
    check("t5_tag",   tag_a, TAG_A);
    check("t5_match", 128'(match_a), 128'd1);

    // 6: Y=128, GAP=0, with a second start while busy
    fill_b();
    exp_tag = TAG_B;
    snap    = pulses_b;
    pulse_start(1'b1);
    feed(1'b1, 32, -1, -1, 5);
    check("t6_ct",     ct_b, CT_B);
    check("t6_tag",    tag_b, TAG_B);
    check("t6_match",  128'(match_b), 128'd1);
    repeat (4) @(negedge clk);
    check("t6_busy_start_ignored", 128'(busy_b), 128'd0);
    check("t6_pulses", 128'(pulses_b - snap), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
